// File: rtl/bias_fetch_ctrl_pkg.sv
// Shared types and constants for the bias fetch path.
package bias_fetch_ctrl_pkg;

  localparam int BIAS_WIDTH     = 32;
  localparam int BIAS_ROM_DEPTH = 256;
  localparam int NUM_COLS       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } bias_fetch_state_t;

  typedef logic [NUM_COLS-1:0][BIAS_WIDTH-1:0] bias_vec_t;

endpackage

// File: rtl/bias_fetch_ctrl.sv
// Fetches one group of per-column biases from the bias ROM and presents
// the assembled vector to the requantize stage with a valid/ready handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; parameters latched and vector cleared on start
// FETCH | one ROM issue per cycle, issue_idx = 0..NUM_COLS-1
// DRAIN | last ROM word lands in the capture stage; vector complete next
// HOLD  | bias_valid high, waiting for bias_ready
module bias_fetch_ctrl
  import bias_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH    = bias_fetch_ctrl_pkg::BIAS_WIDTH,
  parameter int DEPTH    = bias_fetch_ctrl_pkg::BIAS_ROM_DEPTH,
  parameter int NUM_COLS = bias_fetch_ctrl_pkg::NUM_COLS,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [AW-1:0]                   layer_base,
  input  logic [AW:0]                     ch_group_start,
  input  logic [AW:0]                     num_channels,
  output logic                            rom_read_enable,
  output logic [AW-1:0]                   rom_addr,
  input  logic [WIDTH-1:0]                rom_bias_in,
  output logic [NUM_COLS-1:0][WIDTH-1:0]  bias_out,
  output logic                            bias_valid,
  input  logic                            bias_ready,
  output logic                            busy
);

  localparam int IW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  bias_fetch_state_t state;
  logic [IW-1:0]     issue_idx;
  logic [AW-1:0]     base_q;
  logic [AW:0]       grp_q;
  logic [AW:0]       nch_q;

  // One-cycle delay stage matching the ROM read latency.
  logic              cap_valid;
  logic [IW-1:0]     cap_idx;
  logic              cap_active;

  logic [AW+1:0]     ch_sum;
  logic              col_active;
  logic [AW-1:0]     addr_sum;

  // Channel compare is one bit wider than the operands so the sum never wraps;
  // the address sum truncates to AW bits, which wraps at the ROM depth.
  always_comb begin
    ch_sum          = {1'b0, grp_q} + (AW+2)'(issue_idx);
    col_active      = ch_sum < {1'b0, nch_q};
    addr_sum        = base_q + grp_q[AW-1:0] + AW'(issue_idx);
    rom_read_enable = (state == FETCH) && col_active;
    rom_addr        = rom_read_enable ? addr_sum : '0;
    busy            = (state != IDLE);
  end

  // Sequencer, capture stage and output vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      issue_idx  <= '0;
      base_q     <= '0;
      grp_q      <= '0;
      nch_q      <= '0;
      cap_valid  <= 1'b0;
      cap_idx    <= '0;
      cap_active <= 1'b0;
      bias_out   <= '0;
      bias_valid <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      if (cap_valid) begin
        bias_out[cap_idx] <= cap_active ? rom_bias_in : '0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= layer_base;
            grp_q     <= ch_group_start;
            nch_q     <= num_channels;
            bias_out  <= '0;
            issue_idx <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          cap_valid  <= 1'b1;
          cap_idx    <= issue_idx;
          cap_active <= col_active;
          issue_idx  <= issue_idx + 1'b1;
          if (issue_idx == IW'(NUM_COLS - 1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          bias_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (bias_ready) begin
            bias_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
